// File: rtl/collect_interface_pkg.sv
// Shared types and sizing helpers for the collect_interface slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collect_interface_pkg;

    localparam int TS_W_DEFAULT = 16;

`ifdef COLLECT_INTERFACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ARM0 = 2'd0,
        ARM1 = 2'd1,
        RUN  = 2'd2
    } arm_state_e;

    // Event record width: optional timestamp prefix plus mask and value per instance.
    function automatic int evt_width(input int n, input bit ts_en, input int ts_w);
        return ts_en ? (ts_w + 2 * n) : (2 * n);
    endfunction

endpackage

// File: rtl/collect_interface_if.sv
// Single-bit monitored link written by a per-instance driver, read by the collector.
// Latency: combinational wire bundle.
// Backpressure: none; the sink only observes.
interface intf;
    logic logic_in_intf;

    modport source (output logic_in_intf);
    modport sink   (input  logic_in_intf);
endinterface

// File: rtl/collect_interface_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Latency: one cycle push-to-visible; no fall-through when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module collect_interface_fifo #(
    parameter  int W     = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/collect_interface.sv
// Samples N intf links every cycle and queues one event per change cycle; optional timestamp via COLLECT_INTERFACE_TIMESTAMP_EN.
// Latency: change stable before edge k is queued at edge k+1, evt_valid high after edge k+1.
// Backpressure: valid/ready drain; events arriving while the FIFO is full and not popping are dropped and counted.
module collect_interface
    import collect_interface_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    parameter  int TS_W  = TS_W_DEFAULT,
    localparam int EVT_W = evt_width(N, TS_EN, TS_W),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    intf.sink                ifs [N-1:0],
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] drop_cnt
);

    arm_state_e       state;
    logic [N-1:0]     sample;
    logic [N-1:0]     cur_q;
    logic [N-1:0]     prev_q;
    logic [N-1:0]     mask;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [EVT_W-1:0] push_data;
    logic             unused_fifo_count;

    for (genvar i = 0; i < N; i++) begin : g_sample
        assign sample[i] = ifs[i].logic_in_intf;
    end

    assign mask     = cur_q ^ prev_q;
    // Only RUN compares two real samples; ARM phases still hold reset values.
    assign push_req = (state == RUN) && (mask != '0);
    assign pop      = evt_valid && evt_ready;
    assign drop     = push_req && fifo_full && !pop;

    // Occupancy is tracked inside the FIFO; full/empty are all the collector needs.
    assign unused_fifo_count = ^fifo_count;

    // Two-stage sample pipeline feeding the change detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= sample;
            prev_q <= cur_q;
        end
    end

    // Arming sequence: two fill cycles, then RUN until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARM0;
        end else begin
            case (state)
                ARM0:    state <= ARM1;
                ARM1:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef COLLECT_INTERFACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp; the value at the push edge prefixes the event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign push_data = {ts_q, mask, cur_q};
`else
    assign push_data = {mask, cur_q};
`endif

    // Sticky overflow flag and saturating drop count; a same-cycle drop beats the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

    collect_interface_fifo #(
        .W     (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_collect_interface.sv
// Self-checking bench for collect_interface with N=2, DEPTH=4.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercised via evt_ready tables and a scoreboard queue.
module tb_collect_interface;
    import collect_interface_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int TS_W  = 16;
    localparam int EVT_W = evt_width(N, TS_EN, TS_W);

    logic             clk;
    logic             rst_n;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic             ovf;
    logic             clr_ovf;
    logic [CNT_W-1:0] drop_cnt;

    intf ifs [N-1:0] ();

    collect_interface #(
        .N     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .TS_W  (TS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifs       (ifs),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] in_val;
        bit         exp_vld;
        logic [1:0] exp_mask;
        logic [1:0] exp_val;
    } vec_t;

    vec_t       vecs [14];
    logic [3:0] sb [$];
    logic [1:0] cur_in;
    int         exp_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] v);
        ifs[0].logic_in_intf = v[0];
        ifs[1].logic_in_intf = v[1];
    endtask

    // Drive a new input value and record the event it is expected to create.
    task automatic change(input logic [1:0] v);
        if (sb.size() < DEPTH) sb.push_back({v ^ cur_in, v});
        else exp_drops++;
        cur_in = v;
        set_in(v);
        tick();
    endtask

    task automatic drain(input int expect_n);
        int got;
        got = 0;
        evt_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            if (evt_valid) begin
                chk("drain_data", 32'(evt_data[2*N-1:0]), 32'(sb.pop_front()));
                got++;
            end
            tick();
        end
        evt_ready = 1'b0;
        chk("drain_count", got, expect_n);
        chk("drain_empty_after", 32'(evt_valid), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // in, valid, mask, value  (row k = input before edge k after reset release)
        vecs[0]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{2'b01, 1'b1, 2'b01, 2'b01};
        vecs[7]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[9]  = '{2'b00, 1'b1, 2'b01, 2'b00};
        vecs[10] = '{2'b00, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{2'b11, 1'b0, 2'b00, 2'b00};
        vecs[12] = '{2'b11, 1'b1, 2'b11, 2'b11};
        vecs[13] = '{2'b11, 1'b0, 2'b00, 2'b00};

        rst_n     = 1'b0;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        exp_drops = 0;
        cur_in    = 2'b00;
        set_in(2'b00);
        tick();
        tick();
        chk("rst_valid", 32'(evt_valid), 32'(0));
        chk("rst_data", 32'(evt_data), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        rst_n = 1'b1;

        // Quiet arming, single-bit change, falling change and a two-bit change.
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].in_val);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld)
                chk($sformatf("vec%0d_data", i), 32'(evt_data[2*N-1:0]),
                    32'({vecs[i].exp_mask, vecs[i].exp_val}));
        end
        cur_in = 2'b11;

        // Overflow: six change cycles into a stalled 4-deep FIFO.
        evt_ready = 1'b0;
        change(2'b10);
        change(2'b00);
        change(2'b01);
        change(2'b11);
        change(2'b10);
        change(2'b00);
        tick();
        chk("ovf_set", 32'(ovf), 32'(1));
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        chk("ovf_drop_cnt_two", 32'(exp_drops), 32'(2));
        chk("ovf_head", 32'(evt_data[2*N-1:0]), 32'(sb[0]));
        tick();
        chk("ovf_head_stable", 32'(evt_data[2*N-1:0]), 32'(sb[0]));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'(0));
        chk("clr_drop_cnt", 32'(drop_cnt), 32'(0));
        drain(4);

        // Full FIFO with a push and a pop on the same edge: nothing lost.
        change(2'b01);
        change(2'b11);
        change(2'b10);
        change(2'b00);
        tick();
        set_in(2'b01);
        tick();
        evt_ready = 1'b1;
        chk("full_pp_head", 32'(evt_data[2*N-1:0]), 32'(sb.pop_front()));
        sb.push_back({2'b01 ^ cur_in, 2'b01});
        cur_in = 2'b01;
        tick();
        evt_ready = 1'b0;
        chk("full_pp_ovf", 32'(ovf), 32'(0));
        chk("full_pp_drop_cnt", 32'(drop_cnt), 32'(0));
        chk("full_pp_valid", 32'(evt_valid), 32'(1));
        drain(4);

        // Mid-operation reset flushes queued events; arming suppresses startup events.
        change(2'b00);
        change(2'b01);
        change(2'b00);
        tick();
        chk("pre_rst_valid", 32'(evt_valid), 32'(1));
        rst_n = 1'b0;
        set_in(2'b10);
        tick();
        chk("mid_rst_valid", 32'(evt_valid), 32'(0));
        chk("mid_rst_data", 32'(evt_data), 32'(0));
        chk("mid_rst_ovf", 32'(ovf), 32'(0));
        sb.delete();
        rst_n = 1'b1;
        set_in(2'b11);
        for (int e = 0; e < 4; e++) begin
            tick();
            chk($sformatf("arm_quiet%0d", e), 32'(evt_valid), 32'(0));
        end
        set_in(2'b01);
        tick();
        chk("post_rst_latency", 32'(evt_valid), 32'(0));
        tick();
        chk("post_rst_valid", 32'(evt_valid), 32'(1));
        chk("post_rst_data", 32'(evt_data[2*N-1:0]), 32'(4'b1001));
`ifdef COLLECT_INTERFACE_TIMESTAMP_EN
        chk("post_rst_ts", 32'(evt_data[EVT_W-1 -: TS_W]), 32'(5));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
